// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen geometry, ball state and coordinate types for pong
package pong_pkg;
   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;
   localparam int BORDER    = 8;

   typedef enum logic {
      SERVE = 1'b0,
      PLAY  = 1'b1
   } ball_state_t;

   typedef logic [9:0] xcoord_t;
   typedef logic [8:0] ycoord_t;
endpackage

// File: rtl/pong_frame_tick.sv
// rtl/pong_frame_tick.sv - single-cycle frame strobe on the first blanked line
module pong_frame_tick
   import pong_pkg::*;
(
   input  logic [9:0] counterx,
   input  logic [8:0] countery,
   output logic       tick
);
   assign tick = (counterx == 10'd0) && (countery == ycoord_t'(V_VISIBLE));
endmodule

// File: rtl/pong_ball.sv
// rtl/pong_ball.sv - ball motion, wall/paddle collision and per-pixel ball_on
module pong_ball
   import pong_pkg::*;
#(
   parameter int BALL_SIZE    = 8,
   parameter int SPEED        = 2,
   parameter int PADDLE_X     = 16,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] counterx,
   input  logic [8:0] countery,
   input  logic [8:0] paddle_y,
   output logic       ball_on,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic       hit,
   output logic       miss,
   output logic       serving
);
   localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam xcoord_t CENTRE_X = xcoord_t'(H_VISIBLE / 2 - BALL_SIZE / 2);
   localparam ycoord_t CENTRE_Y = ycoord_t'(V_VISIBLE / 2 - BALL_SIZE / 2);

   // Collision maths runs in 11-bit signed so a step past 0 stays negative.
   typedef logic signed [10:0] s11_t;
   localparam s11_t S_SPEED  = s11_t'(SPEED);
   localparam s11_t S_SIZE   = s11_t'(BALL_SIZE);
   localparam s11_t S_TOP    = s11_t'(BORDER);
   localparam s11_t S_BOTTOM = s11_t'(V_VISIBLE - BORDER);
   localparam s11_t S_RIGHT  = s11_t'(H_VISIBLE - BORDER);
   localparam s11_t S_FACE   = s11_t'(PADDLE_X + PADDLE_W);
   localparam s11_t S_PAD_H  = s11_t'(PADDLE_H);

   ball_state_t   state, state_next;
   logic [CW-1:0] serve_cnt, serve_cnt_next;
   xcoord_t       ball_x_next;
   ycoord_t       ball_y_next;
   logic          dir_x, dir_y, dir_x_next, dir_y_next;
   logic          hit_next, miss_next, ball_on_next, tick;
   s11_t          bx, by, py, nx, ny;

   pong_frame_tick u_frame_tick (
      .counterx (counterx),
      .countery (countery),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SERVE;
         serve_cnt <= '0;
         ball_x    <= CENTRE_X;
         ball_y    <= CENTRE_Y;
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         ball_on   <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
      end else begin
         state     <= state_next;
         serve_cnt <= serve_cnt_next;
         ball_x    <= ball_x_next;
         ball_y    <= ball_y_next;
         dir_x     <= dir_x_next;
         dir_y     <= dir_y_next;
         ball_on   <= ball_on_next;
         hit       <= hit_next;
         miss      <= miss_next;
      end
   end

   always_comb begin
      state_next     = state;
      serve_cnt_next = serve_cnt;
      ball_x_next    = ball_x;
      ball_y_next    = ball_y;
      dir_x_next     = dir_x;
      dir_y_next     = dir_y;
      hit_next       = 1'b0;
      miss_next      = 1'b0;
      bx = s11_t'({1'b0, ball_x});
      by = s11_t'({2'b00, ball_y});
      py = s11_t'({2'b00, paddle_y});
      nx = dir_x ? bx + S_SPEED : bx - S_SPEED;
      ny = dir_y ? by + S_SPEED : by - S_SPEED;
      ball_on_next = (counterx >= ball_x) &&
                     ({1'b0, counterx} < {1'b0, ball_x} + 11'(BALL_SIZE)) &&
                     (countery >= ball_y) &&
                     ({1'b0, countery} < {1'b0, ball_y} + 10'(BALL_SIZE));

      if (tick) begin
         if (state == SERVE) begin
            ball_x_next = CENTRE_X;
            ball_y_next = CENTRE_Y;
            if (serve_cnt == CW'(SERVE_FRAMES - 1)) begin
               state_next     = PLAY;
               serve_cnt_next = '0;
            end else begin
               serve_cnt_next = serve_cnt + CW'(1);
            end
         end else begin
            if (ny < S_TOP) begin
               ball_y_next = ycoord_t'(S_TOP);
               dir_y_next  = 1'b1;
            end else if (ny + S_SIZE > S_BOTTOM) begin
               ball_y_next = ycoord_t'(S_BOTTOM - S_SIZE);
               dir_y_next  = 1'b0;
            end else begin
               ball_y_next = ycoord_t'(ny);
            end

            // Paddle test uses the pre-move row so the face crossing is judged where the ball was.
            if (nx + S_SIZE > S_RIGHT) begin
               ball_x_next = xcoord_t'(S_RIGHT - S_SIZE);
               dir_x_next  = 1'b0;
            end else if (!dir_x && (bx >= S_FACE) && (nx < S_FACE) &&
                         (by + S_SIZE > py) && (by < py + S_PAD_H)) begin
               ball_x_next = xcoord_t'(S_FACE);
               dir_x_next  = 1'b1;
               hit_next    = 1'b1;
            end else if (nx < S_TOP) begin
               miss_next   = 1'b1;
               state_next  = SERVE;
               ball_x_next = CENTRE_X;
               ball_y_next = CENTRE_Y;
               dir_x_next  = 1'b1;
               dir_y_next  = ~dir_y_next;
            end else begin
               ball_x_next = xcoord_t'(nx);
            end
         end
      end
   end

   always_comb begin
      serving = (state == SERVE);
   end
endmodule

// File: tb/tb_pong_ball.sv
// tb/tb_pong_ball.sv - randomized self-checking bench for pong_ball against a frame-level model
module tb_pong_ball;
   localparam int BS           = 8;
   localparam int SERVE_FRAMES = 60;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] counterx;
   logic [8:0] countery;
   logic [8:0] paddle_y;
   logic       ball_on, hit, miss, serving;
   logic [9:0] ball_x;
   logic [8:0] ball_y;

   int n_cmp = 0;
   int n_bad = 0;
   int hits_seen = 0;
   int misses_seen = 0;
   int tick_no = 0;

   bit m_serving, m_dx, m_dy, m_hit, m_miss, m_on;
   int m_cnt, m_x, m_y;

   pong_ball dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .counterx (counterx),
      .countery (countery),
      .paddle_y (paddle_y),
      .ball_on  (ball_on),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .hit      (hit),
      .miss     (miss),
      .serving  (serving)
   );

   always #20 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_serving = 1; m_cnt = 0; m_x = 316; m_y = 236;
      m_dx = 1; m_dy = 1; m_hit = 0; m_miss = 0; m_on = 0;
   endtask

   task automatic model_step(input int cx, input int cy, input int p);
      int nx, ny, oy;
      m_on   = (cx >= m_x) && (cx < m_x + BS) && (cy >= m_y) && (cy < m_y + BS);
      m_hit  = 0;
      m_miss = 0;
      if (cx == 0 && cy == 480) begin
         if (m_serving) begin
            if (m_cnt == SERVE_FRAMES - 1) begin
               m_serving = 0;
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end else begin
            oy = m_y;
            nx = m_x + (m_dx ? 2 : -2);
            ny = m_y + (m_dy ? 2 : -2);
            if (ny < 8) begin
               m_y = 8; m_dy = 1;
            end else if (ny + BS > 472) begin
               m_y = 472 - BS; m_dy = 0;
            end else begin
               m_y = ny;
            end
            if (nx + BS > 632) begin
               m_x = 632 - BS; m_dx = 0;
            end else if (!m_dx && m_x >= 24 && nx < 24 && oy + BS > p && oy < p + 64) begin
               m_x = 24; m_dx = 1; m_hit = 1; hits_seen++;
            end else if (nx < 8) begin
               m_miss = 1; misses_seen++; m_serving = 1;
               m_x = 316; m_y = 236; m_dx = 1; m_dy = ~m_dy;
            end else begin
               m_x = nx;
            end
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step(int'(counterx), int'(countery), int'(paddle_y));
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("ball_x",  int'(ball_x),  m_x);
         chk("ball_y",  int'(ball_y),  m_y);
         chk("serving", int'(serving), int'(m_serving));
         chk("hit",     int'(hit),     int'(m_hit));
         chk("miss",    int'(miss),    int'(m_miss));
         chk("ball_on", int'(ball_on), int'(m_on));
      end
   end

   task automatic set_rand();
      if ($urandom_range(0, 2) != 0) begin
         counterx = 10'(m_x - 3 + int'($urandom_range(0, BS + 5)));
         countery = 9'(m_y - 3 + int'($urandom_range(0, BS + 5)));
      end else begin
         counterx = 10'($urandom_range(0, 767));
         countery = 9'($urandom_range(0, 511));
         if (counterx == 10'd0 && countery == 9'd480) countery = 9'd0;
      end
      paddle_y = 9'($urandom);
   endtask

   // pmode >= 0 pins the paddle row; otherwise half the ticks track the ball.
   task automatic frame(input int idle, input int pmode);
      int p;
      for (int i = 0; i < idle; i++) begin
         @(negedge clk);
         set_rand();
         if (pmode >= 0) paddle_y = 9'(pmode);
      end
      @(negedge clk);
      counterx = 10'd0;
      countery = 9'd480;
      if (pmode >= 0) begin
         paddle_y = 9'(pmode);
      end else if ($urandom_range(0, 1) != 0) begin
         p = m_y - 63 + int'($urandom_range(0, 70));
         if (p < 0) p = 0;
         paddle_y = 9'(p);
      end else begin
         paddle_y = 9'($urandom);
      end
      @(negedge clk);
      set_rand();
      if (pmode >= 0) paddle_y = 9'(pmode);
      tick_no++;
   endtask

   initial begin
      int waits;
      reset_n  = 1'b0;
      counterx = 10'd100;
      countery = 9'd100;
      paddle_y = 9'd0;
      repeat (3) @(negedge clk);
      chk("rst_ball_x",  int'(ball_x),  316);
      chk("rst_ball_y",  int'(ball_y),  236);
      chk("rst_serving", int'(serving), 1);
      chk("rst_hit",     int'(hit),     0);
      chk("rst_miss",    int'(miss),    0);
      chk("rst_ball_on", int'(ball_on), 0);
      reset_n = 1'b1;

      for (int line = 236; line <= 244; line += 8) begin
         for (int x = 312; x <= 327; x++) begin
            @(negedge clk);
            counterx = 10'(x);
            countery = 9'(line);
            @(negedge clk);
            chk("sweep_ball_on", int'(ball_on), int'(line == 236 && x >= 316 && x <= 323));
         end
      end

      for (int t = 1; t <= 60; t++) begin
         frame($urandom_range(1, 4), 200);
         if (t < 60) chk("serve_serving", int'(serving), 1);
      end
      chk("launch_serving", int'(serving), 0);
      chk("launch_x", int'(ball_x), 316);
      frame(2, 200);
      chk("first_move_x", int'(ball_x), 318);
      chk("first_move_y", int'(ball_y), 238);
      while (tick_no < 215) frame($urandom_range(0, 3), 200);
      chk("corner_x", int'(ball_x), 624);
      chk("corner_y", int'(ball_y), 384);
      while (tick_no < 516) frame($urandom_range(0, 3), 200);
      chk("paddle_hit", int'(hit), 1);
      chk("paddle_x", int'(ball_x), 24);
      chk("paddle_y", int'(ball_y), 232);
      @(negedge clk);
      chk("hit_width", int'(hit), 0);

      for (int f = 0; f < 1500; f++) frame($urandom_range(0, 4), -1);

      waits = 0;
      while (m_serving && waits < 200) begin
         frame(1, -1);
         waits++;
      end
      chk("play_before_reset", int'(m_serving), 0);
      @(posedge clk);
      #5 reset_n = 1'b0;
      #1;
      chk("async_ball_x",  int'(ball_x),  316);
      chk("async_ball_y",  int'(ball_y),  236);
      chk("async_serving", int'(serving), 1);
      chk("async_hit",     int'(hit),     0);
      chk("async_miss",    int'(miss),    0);
      chk("async_ball_on", int'(ball_on), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int f = 0; f < 1200; f++) frame($urandom_range(0, 4), -1);
      chk("hits_observed",   int'(hits_seen > 0),   1);
      chk("misses_observed", int'(misses_seen > 0), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pong_ball.md
# pong_ball

Ball motion and paddle collision engine for the VGA pong display. Runs on the 25 MHz pixel clock alongside the X/Y sync counters. Consumes the raster position and the paddle position, advances the ball once per frame, and emits a per-pixel `ball_on` for the colour compositor, which ORs it with the border. Also emits `hit` and `miss` event pulses for a downstream score block.

## Interface
- `BALL_SIZE`, default 8: ball edge length in pixels (square).
- `SPEED`, default 2: pixels moved per frame on each axis.
- `PADDLE_X`, default 16: left column of the paddle.
- `PADDLE_W`, default 8: paddle width in pixels.
- `PADDLE_H`, default 64: paddle height in pixels.
- `SERVE_FRAMES`, default 60: frames the ball waits at centre before launch.
- `clk`  in  1: 25 MHz pixel clock, same net that drives the sync counters.
- `reset_n`  in  1: asynchronous, active-low reset.
- `counterx`  in  10: raster X; 0..767, visible 0..639.
- `countery`  in  9: raster Y; 0..511, visible 0..479.
- `paddle_y`  in  9: paddle top row; sampled only on the frame tick.
- `ball_on`  out  1: registered; current pixel lies inside the ball.
- `ball_x`  out  10: ball left column.
- `ball_y`  out  9: ball top row.
- `hit`  out  1: one-cycle pulse on a paddle bounce.
- `miss`  out  1: one-cycle pulse when the ball passes the paddle.
- `serving`  out  1: high while in SERVE.

## Operation
- Playfield is bounded by the 8-px border: x 8..631, y 8..471.
- Centre position is (320-BALL_SIZE/2, 240-BALL_SIZE/2), i.e. (316, 236) by default.
- Frame tick is a single-cycle strobe, true when `counterx==0 && countery==480` (first blanked line). All motion updates happen only on this cycle.
- Direction is held as `dir_x` and `dir_y`, 1 bit each; 1 means +SPEED.
- Next position is computed in 11-bit signed arithmetic: `nx = ball_x ± SPEED`, `ny = ball_y ± SPEED`.
- State SERVE:
  - Ball is held at centre; `serve_cnt` increments on each tick.
  - When `serve_cnt == SERVE_FRAMES-1` on a tick, go to PLAY and clear `serve_cnt`.
- State PLAY, evaluated on each tick in this order:
  1. Y walls.
     - If `ny < 8`: `ball_y` ← 8 and `dir_y` ← 1.
     - Else if `ny + BALL_SIZE > 472`: `ball_y` ← 472-BALL_SIZE and `dir_y` ← 0.
     - Otherwise `ball_y` ← `ny`.
  2. Right wall. If `nx + BALL_SIZE > 632`: `ball_x` ← 632-BALL_SIZE and `dir_x` ← 0.
  3. Paddle.
     - Applies if `dir_x==0`, `ball_x >= PADDLE_X+PADDLE_W`, and `nx < PADDLE_X+PADDLE_W` (the ball crosses the paddle face this frame).
     - Vertical overlap means `ball_y+BALL_SIZE > paddle_y` and `ball_y < paddle_y+PADDLE_H`, using the pre-move `ball_y`.
     - With overlap: `ball_x` ← PADDLE_X+PADDLE_W, `dir_x` ← 1, and `hit` pulses.
  4. Miss.
     - If `nx < 8`: `miss` pulses, state goes to SERVE, the ball returns to centre, `dir_x` ← 1, and `dir_y` toggles (alternates serve angle).
  5. Otherwise `ball_x` ← `nx`.
- Y and X resolve independently in the same tick, so a corner bounce flips both axes.
- `ball_on` is registered: `counterx` in [ball_x, ball_x+BALL_SIZE) and `countery` in [ball_y, ball_y+BALL_SIZE).

## Timing
- Reset values:
  - State SERVE; `serve_cnt` 0.
  - `ball_x` 316, `ball_y` 236.
  - `dir_x` 1, `dir_y` 1.
  - `ball_on`, `hit`, `miss` all 0; `serving` 1.
- `ball_on` lags the raster counters by 1 cycle, matching the compositor's registered colour path.
- Position, direction, state, `hit` and `miss` update on the clock edge that ends the tick cycle. Pulses are exactly 1 cycle wide.
- Position is constant for the whole visible frame, so there is no tearing.
- `paddle_y` may change at any time; only its value in the tick cycle matters.
- Reset asserted mid-frame or mid-serve clears everything immediately (asynchronous). Release takes effect on the next `clk` edge.
- Counters that skip 480 produce no tick, and the ball freezes. This is acceptable; no recovery logic.

## Structure
- Shared `pong_pkg` holds:
  - `H_VISIBLE=640`, `V_VISIBLE=480`, `BORDER=8`.
  - `ball_state_t` enum {SERVE, PLAY}.
  - Coordinate typedefs `xcoord_t` (10 b) and `ycoord_t` (9 b).
- One sub-module, `pong_frame_tick`: compares the raster counters and outputs the registered-free tick strobe. It is reused by the paddle block.

## Test plan
- Reset then release; run 60 frames → `serving` 1 for ticks 1..59, PLAY entered on tick 60; ball first moves to (318, 238) on tick 61.
- Ball in PLAY at y=9, dir_y=0 → next tick `ball_y`=8, dir_y=1. Ball at y=463, dir_y=1 → `ball_y`=464, dir_y=0.
- Ball at x=25, dir_x=0, y=100, `paddle_y`=80 → next tick `ball_x`=24, dir_x=1, `hit` 1 for one cycle.
- Same ball but `paddle_y`=300 → passes the paddle; on the tick where nx<8, `miss` pulses, ball goes to (316, 236), `serving` 1, and dir_y is inverted.
- Ball at (100, 50), sweep the raster → `ball_on` high exactly for x 100..107 on lines 50..57, each one cycle after the matching counters.
- Assert `reset_n` low mid-PLAY at an arbitrary cycle → outputs go to reset values without waiting for `clk`.
